gf180mcu_fd_sc_mcu7t5v0__rcv_filt: RTL

GF180MCU_FD_SC_MCU7T5V0__RCV_FILT -- requirements
Module: gf180mcu_fd_sc_mcu7t5v0__rcv_filt

---
 rtl/gf180mcu_fd_sc_mcu7t5v0__rcv_filt.sv | 43 ++++
 1 files changed

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__rcv_filt.sv
// gf180mcu_fd_sc_mcu7t5v0__rcv_filt: synchronized, digitally filtered receiver; GF180MCU_FD_SC_RCV_EDGE_EN adds ZR/ZF edge pulses
module gf180mcu_fd_sc_mcu7t5v0__rcv_filt #(
  parameter int FILT_CYC = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic I,
  output logic Z,
  output logic ZR,
  output logic ZF
);
  localparam int CW = FILT_CYC > 1 ? $clog2(FILT_CYC) : 1;
  logic s1, s2, ld;
  logic [CW-1:0] cnt;
  assign ld = (s2 != Z) && (cnt == CW'(FILT_CYC - 1));
  always_ff @(posedge CLK) begin
    if (RST) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      cnt <= '0;
      Z   <= 1'b0;
    end else begin
      s1  <= I;
      s2  <= s1;
      cnt <= (s2 == Z || ld) ? '0 : cnt + CW'(1);
      Z   <= ld ? s2 : Z;
    end
  end
`ifdef GF180MCU_FD_SC_RCV_EDGE_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      ZR <= 1'b0;
      ZF <= 1'b0;
    end else begin
      ZR <= ld & s2;
      ZF <= ld & ~s2;
    end
  end
`else
  assign ZR = 1'b0;
  assign ZF = 1'b0;
`endif
endmodule
